cordic_arbiter: RTL and testbench

//  Shares one cordic core (start/x/y -> angle_out/done/ready) among NUM_REQ requesters.

---
 rtl/cordic_arb_pkg.sv | 17 +
 rtl/cordic_rr_pick.sv | 28 ++
 rtl/cordic_arbiter.sv | 129 ++++++++++++
 tb/tb_cordic_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types and widths for the cordic arbiter.
// State encoding, operand/result widths and requester limit.
package cordic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int XY_W    = 8;
  localparam int ANG_W   = 16;
  localparam int MAX_REQ = 8;
  localparam int PW      = $clog2(MAX_REQ);

endpackage

// File: rtl/cordic_rr_pick.sv
// Rotating priority encoder: first set req after ptr, wrapping.
// Purely combinational; any=0 when no request is pending.
module cordic_rr_pick
  import cordic_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    // Walk from lowest priority to highest so the nearest hit wins
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one cordic core among NUM_REQ clients.
// Optional WAIT timeout enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [XY_W*NUM_REQ-1:0] req_x,
  input  logic [XY_W*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [ANG_W-1:0]        rsp_angle,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    cordic_start,
  output logic [XY_W-1:0]         cordic_x,
  output logic [XY_W-1:0]         cordic_y,
  input  logic [ANG_W-1:0]        cordic_angle,
  input  logic                    cordic_done,
  input  logic                    cordic_ready
);

  state_t          state;
  state_t          nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic            go;
  logic            tmo;

  cordic_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (win_any),
    .idx (win_idx)
  );

  assign go   = win_any && cordic_ready;
  assign busy = (state != IDLE);

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (state == WAIT) && (cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (go) nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT:  if (cordic_done || tmo) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt          <= '0;
      rsp_valid    <= '0;
      rsp_angle    <= '0;
      rsp_err      <= 1'b0;
      cordic_start <= 1'b0;
      cordic_x     <= '0;
      cordic_y     <= '0;
      owner        <= '0;
      ptr          <= PW'(NUM_REQ - 1);
    end else begin
      gnt          <= '0;
      rsp_valid    <= '0;
      cordic_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            cordic_x     <= req_x[XY_W*win_idx +: XY_W];
            cordic_y     <= req_y[XY_W*win_idx +: XY_W];
            owner        <= win_idx;
            gnt          <= NUM_REQ'(1) << win_idx;
            cordic_start <= 1'b1;
          end
        end
        WAIT: begin
          // Done beats a simultaneous timeout
          if (cordic_done) begin
            rsp_angle <= cordic_angle;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << owner;
          end else if (tmo) begin
            rsp_angle <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << owner;
          end
        end
        RESP: ptr <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a hand-driven core model.
// Timeout scenarios run only when CORDIC_ARB_TIMEOUT_EN is defined.
module tb_cordic_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_angle;
  logic        rsp_err;
  logic        busy;
  logic        cordic_start;
  logic [7:0]  cordic_x;
  logic [7:0]  cordic_y;
  logic [15:0] cordic_angle = '0;
  logic        cordic_done = 1'b0;
  logic        cordic_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  cordic_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_angle    (rsp_angle),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .cordic_start (cordic_start),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_angle (cordic_angle),
    .cordic_done  (cordic_done),
    .cordic_ready (cordic_ready)
  );

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    n_tests++;
    if ({gnt, rsp_valid, rsp_err, busy, cordic_start} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0",
               {gnt, rsp_valid, rsp_err, busy, cordic_start});
    end
    n_tests++;
    if ({cordic_x, cordic_y, rsp_angle} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {cordic_x, cordic_y, rsp_angle});
    end
  endtask

  task automatic test_single;
    req   = 4'b0001;
    req_x = 32'h0000_0040;
    req_y = 32'h0000_0000;
    tick();
    n_tests++;
    if ({gnt, cordic_start, busy} !== 6'b0001_1_1) begin
      n_fail++;
      $display("FAIL single_gnt: got %b want 000111",
               {gnt, cordic_start, busy});
    end
    n_tests++;
    if ({cordic_x, cordic_y} !== 16'h4000) begin
      n_fail++;
      $display("FAIL single_xy: got %h want 4000", {cordic_x, cordic_y});
    end
    req   = 4'b0000;
    req_x = 32'h0000_007f;
    tick();
    n_tests++;
    if ({gnt, cordic_start, cordic_x} !== {5'b0, 8'h40}) begin
      n_fail++;
      $display("FAIL single_hold: got %h want 040",
               {gnt, cordic_start, cordic_x});
    end
    cordic_done  = 1'b1;
    cordic_angle = 16'h0000;
    tick();
    cordic_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_angle} !== {4'b0001, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL single_rsp: got %h want %h",
               {rsp_valid, rsp_err, rsp_angle}, {4'b0001, 1'b0, 16'h0});
    end
    tick();
    n_tests++;
    if ({rsp_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 0", {rsp_valid, busy});
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] order [5];
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    req_x = 32'h4030_2010;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int budget;
      budget = 0;
      tick();
      while (gnt == 4'b0 && budget < 8) begin
        tick();
        budget++;
      end
      n_tests++;
      if (gnt !== order[k]) begin
        n_fail++;
        $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, order[k]);
      end
      n_tests++;
      if (cordic_x !== 8'(8'h10 * ((k % 4) + 1))) begin
        n_fail++;
        $display("FAIL rr_x%0d: got %h want %h",
                 k, cordic_x, 8'(8'h10 * ((k % 4) + 1)));
      end
      tick();
      cordic_done  = 1'b1;
      cordic_angle = 16'(16'h1000 + k);
      tick();
      cordic_done = 1'b0;
      n_tests++;
      if ({rsp_valid, rsp_angle} !== {order[k], 16'(16'h1000 + k)}) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: got %h want %h",
                 k, {rsp_valid, rsp_angle}, {order[k], 16'(16'h1000 + k)});
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_ready_block;
    logic bad;
    bad = 1'b0;
    cordic_ready = 1'b0;
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gnt !== 4'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL ready_block: got gnt %b busy %b want 0", gnt, busy);
    end
    cordic_ready = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL ready_gnt: got %b want 0010", gnt);
    end
    req = 4'b0000;
    tick();
    cordic_done  = 1'b1;
    cordic_angle = 16'h0abc;
    tick();
    cordic_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_angle} !== {4'b0010, 16'h0abc}) begin
      n_fail++;
      $display("FAIL ready_rsp: got %h want 20abc", {rsp_valid, rsp_angle});
    end
    tick();
  endtask

  task automatic test_reset_mid;
    req = 4'b0100;
    tick();
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_gnt: got %b want 0100", gnt);
    end
    req = 4'b0000;
    tick();
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    n_tests++;
    if ({gnt, rsp_valid, rsp_err, busy, cordic_start, cordic_x,
         cordic_y, rsp_angle} !== 43'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want 0",
               {gnt, rsp_valid, rsp_err, busy, cordic_start, cordic_x,
                cordic_y, rsp_angle});
    end
    cordic_done  = 1'b1;
    cordic_angle = 16'h5555;
    tick();
    cordic_done = 1'b0;
    n_tests++;
    if ({rsp_valid, busy, rsp_angle} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_late_done: got %h want 0",
               {rsp_valid, busy, rsp_angle});
    end
    req = 4'b1111;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_regrant: got %b want 0001", gnt);
    end
    req = 4'b0000;
    tick();
    cordic_done  = 1'b1;
    cordic_angle = 16'h0777;
    tick();
    cordic_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_angle} !== {4'b0001, 16'h0777}) begin
      n_fail++;
      $display("FAIL mid_rsp: got %h want 10777", {rsp_valid, rsp_angle});
    end
    tick();
  endtask

`ifdef CORDIC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic bad;
    bad = 1'b0;
    req = 4'b1000;
    tick();
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL tmo_gnt: got %b want 1000", gnt);
    end
    req = 4'b0000;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (rsp_valid !== 4'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL tmo_early: got rsp_valid %b want 0", rsp_valid);
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_angle} !== {4'b1000, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL tmo_rsp: got %h want %h",
               {rsp_valid, rsp_err, rsp_angle}, {4'b1000, 1'b1, 16'h0});
    end
    tick();
  endtask

  task automatic test_done_at_timeout;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    for (int i = 0; i < 7; i++) tick();
    cordic_done  = 1'b1;
    cordic_angle = 16'h1234;
    tick();
    cordic_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_angle} !== {4'b0001, 1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL tmo_tie: got %h want %h",
               {rsp_valid, rsp_err, rsp_angle}, {4'b0001, 1'b0, 16'h1234});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ready_block();
    test_reset_mid();
`ifdef CORDIC_ARB_TIMEOUT_EN
    test_timeout();
    test_done_at_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
